// File: rtl/turn_sequencer.sv
// turn_sequencer
//    Game-turn controller for the shared 32x4 code RAM. Player 1 records a
//    symbol code, player 2 replays it guess by guess against the stored
//    code, then a result is shown. Owns the RAM port and lends it to the
//    VGA readout only while idle or showing a result.
//
// Ports
//    clock, resetn          system clock, asynchronous active-low reset
//    start                  1-cycle pulse, begins a round in IDLE/RESULT
//    p1_valid/_symbol/_done player 1 symbol strobe, symbol, end of recording
//    p1_ready               p1 symbol accepted this cycle if valid
//    p2_valid/_symbol/_done player 2 guess strobe, guess, give up
//    p2_ready               p2 guess accepted this cycle if valid
//    vga_req, vga_addr      VGA readout request and read address
//    vga_grant              vga_addr drives the RAM this cycle
//    ram_addr/_data/_wren   RAM port (combinational)
//    ram_q                  RAM read data, one cycle after address sampled
//    state                  current state encoding for the debug display
//    code_len, match_cnt    symbols recorded, guesses matched
//    result_valid, correct  showing a result, full code matched
module turn_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              p1_valid,
   input  logic [DATA_W-1:0] p1_symbol,
   input  logic              p1_done,
   output logic              p1_ready,
   input  logic              p2_valid,
   input  logic [DATA_W-1:0] p2_symbol,
   input  logic              p2_done,
   output logic              p2_ready,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_grant,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic [2:0]        state,
   output logic [5:0]        code_len,
   output logic [5:0]        match_cnt,
   output logic              result_valid,
   output logic              correct
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      P1_REC  = 3'd1,
      P2_PLAY = 3'd2,
      P2_CMP  = 3'd3,
      RESULT  = 3'd4
   } state_t;

   state_t              cur, nxt;
   logic [ADDR_W-1:0]   wr_ptr, wr_ptr_n;
   logic [5:0]          rd_ptr, rd_ptr_n;
   logic [5:0]          code_len_n, match_n;
   logic                correct_n;
   logic [DATA_W-1:0]   guess, guess_n;
   logic                done_seen, done_seen_n;
   logic                hit, last;

   assign state        = cur;
   assign ram_data     = p1_symbol;
   assign result_valid = (cur == RESULT);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cur       <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         code_len  <= '0;
         match_cnt <= '0;
         correct   <= 1'b0;
         guess     <= '0;
         done_seen <= 1'b0;
      end else begin
         cur       <= nxt;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         code_len  <= code_len_n;
         match_cnt <= match_n;
         correct   <= correct_n;
         guess     <= guess_n;
         done_seen <= done_seen_n;
      end
   end

   always_comb begin
      nxt         = cur;
      wr_ptr_n    = wr_ptr;
      rd_ptr_n    = rd_ptr;
      code_len_n  = code_len;
      match_n     = match_cnt;
      correct_n   = correct;
      guess_n     = guess;
      done_seen_n = done_seen;
      p1_ready    = 1'b0;
      p2_ready    = 1'b0;
      vga_grant   = 1'b0;
      ram_addr    = '0;
      ram_wren    = 1'b0;
      hit         = 1'b0;
      last        = 1'b0;

      case (cur)
         IDLE, RESULT: begin
            vga_grant = vga_req;
            if (vga_req) ram_addr = vga_addr;
            if (start) begin
               nxt         = P1_REC;
               wr_ptr_n    = '0;
               rd_ptr_n    = '0;
               code_len_n  = '0;
               match_n     = '0;
               correct_n   = 1'b0;
               done_seen_n = 1'b0;
            end
         end

         P1_REC: begin
            p1_ready = (code_len < 6'(DEPTH));
            ram_addr = wr_ptr;
            if (p1_valid && p1_ready) begin
               ram_wren   = 1'b1;
               wr_ptr_n   = wr_ptr + 1'b1;
               code_len_n = code_len + 6'd1;
            end
            // A write in the same cycle as done counts toward the length.
            if (p1_done) begin
               if (code_len_n == 6'd0) begin
                  nxt       = RESULT;
                  correct_n = 1'b0;
               end else begin
                  nxt = P2_PLAY;
               end
            end
         end

         P2_PLAY: begin
            p2_ready = 1'b1;
            ram_addr = rd_ptr[ADDR_W-1:0];
            if (p2_done) done_seen_n = 1'b1;
            if (p2_valid) begin
               guess_n = p2_symbol;
               nxt     = P2_CMP;
            end else if (p2_done) begin
               nxt       = RESULT;
               correct_n = 1'b0;
            end
         end

         P2_CMP: begin
            ram_addr = rd_ptr[ADDR_W-1:0];
            hit      = (ram_q == guess);
            last     = ((rd_ptr + 6'd1) == code_len);
            match_n  = match_cnt + {5'd0, hit};
            rd_ptr_n = rd_ptr + 6'd1;
            // A give-up seen while waiting or comparing still lets the
            // in-flight guess be scored before the round ends.
            if (last || done_seen || p2_done) begin
               nxt       = RESULT;
               correct_n = last && (match_n == code_len) && (code_len != 6'd0);
            end else begin
               nxt = P2_PLAY;
            end
         end

         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;

   logic       clock, resetn, start;
   logic       p1_valid, p1_done, p1_ready;
   logic [3:0] p1_symbol;
   logic       p2_valid, p2_done, p2_ready;
   logic [3:0] p2_symbol;
   logic       vga_req, vga_grant;
   logic [4:0] vga_addr, ram_addr;
   logic [3:0] ram_data, ram_q;
   logic       ram_wren;
   logic [2:0] state;
   logic [5:0] code_len, match_cnt;
   logic       result_valid, correct;

   int tests = 0;
   int fails = 0;

   logic [3:0] mem [32];

   turn_sequencer #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
      .clock(clock), .resetn(resetn), .start(start),
      .p1_valid(p1_valid), .p1_symbol(p1_symbol), .p1_done(p1_done), .p1_ready(p1_ready),
      .p2_valid(p2_valid), .p2_symbol(p2_symbol), .p2_done(p2_done), .p2_ready(p2_ready),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_grant(vga_grant),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
      .state(state), .code_len(code_len), .match_cnt(match_cnt),
      .result_valid(result_valid), .correct(correct)
   );

   // ram32x4 behavioural stand-in: synchronous write, registered read
   always @(posedge clock) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic p1_write(input logic [3:0] s);
      p1_valid = 1'b1; p1_symbol = s;
      @(negedge clock);
      p1_valid = 1'b0;
   endtask

   task automatic p1_finish();
      p1_done = 1'b1;
      @(negedge clock);
      p1_done = 1'b0;
   endtask

   task automatic p2_quit();
      p2_done = 1'b1;
      @(negedge clock);
      p2_done = 1'b0;
   endtask

   task automatic p2_guess(input logic [3:0] s, output logic [2:0] mid_state);
      int n = 0;
      while (p2_ready !== 1'b1 && n < 10) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (p2_ready !== 1'b1) begin
         fails++;
         $display("FAIL p2_ready_wait: got %b expected 1 within 10 cycles", p2_ready);
      end
      p2_valid = 1'b1; p2_symbol = s;
      @(negedge clock);
      p2_valid = 1'b0;
      mid_state = state;
      @(negedge clock);
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #1 resetn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
      tests++; if (code_len !== 6'd0 || match_cnt !== 6'd0) begin fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", code_len, match_cnt); end
      tests++; if ({result_valid, correct, p1_ready, p2_ready, vga_grant, ram_wren} !== 6'b0) begin
         fails++; $display("FAIL reset_flags: got %b expected 000000", {result_valid, correct, p1_ready, p2_ready, vga_grant, ram_wren});
      end
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic record_371();
      pulse_start();
      p1_write(4'd3); p1_write(4'd7); p1_write(4'd1);
      p1_finish();
   endtask

   task automatic test_record();
      record_371();
      tests++; if (code_len !== 6'd3) begin fails++; $display("FAIL record_len: got %0d expected 3", code_len); end
      tests++; if (state !== 3'd2) begin fails++; $display("FAIL record_state: got %0d expected 2", state); end
      tests++; if (mem[0] !== 4'd3 || mem[1] !== 4'd7 || mem[2] !== 4'd1) begin
         fails++; $display("FAIL record_ram: got %0d,%0d,%0d expected 3,7,1", mem[0], mem[1], mem[2]);
      end
   endtask

   task automatic test_replay_match();
      logic [2:0] ms;
      p2_guess(4'd3, ms);
      p2_guess(4'd7, ms);
      p2_guess(4'd1, ms);
      tests++; if (ms !== 3'd3) begin fails++; $display("FAIL match_latency_mid: got %0d expected 3", ms); end
      tests++; if (state !== 3'd4) begin fails++; $display("FAIL match_latency_end: got %0d expected 4", state); end
      tests++; if (match_cnt !== 6'd3) begin fails++; $display("FAIL match_cnt: got %0d expected 3", match_cnt); end
      tests++; if (correct !== 1'b1 || result_valid !== 1'b1) begin fails++; $display("FAIL match_correct: got %b%b expected 11", correct, result_valid); end
   endtask

   task automatic test_replay_mismatch();
      logic [2:0] ms;
      record_371();
      p2_guess(4'd3, ms);
      p2_guess(4'd9, ms);
      p2_guess(4'd1, ms);
      tests++; if (state !== 3'd4) begin fails++; $display("FAIL miss_state: got %0d expected 4", state); end
      tests++; if (match_cnt !== 6'd2) begin fails++; $display("FAIL miss_cnt: got %0d expected 2", match_cnt); end
      tests++; if (correct !== 1'b0) begin fails++; $display("FAIL miss_correct: got %b expected 0", correct); end
      pulse_start();
      tests++; if (state !== 3'd1) begin fails++; $display("FAIL restart_state: got %0d expected 1", state); end
      tests++; if (code_len !== 6'd0 || match_cnt !== 6'd0 || correct !== 1'b0 || result_valid !== 1'b0) begin
         fails++; $display("FAIL restart_clear: got %0d/%0d/%b/%b expected 0/0/0/0", code_len, match_cnt, correct, result_valid);
      end
      vga_req = 1'b1; vga_addr = 5'd2;
      #1;
      tests++; if (vga_grant !== 1'b0) begin fails++; $display("FAIL vga_in_rec: got %b expected 0", vga_grant); end
      vga_req = 1'b0;
   endtask

   task automatic test_overflow();
      // already in P1_REC with an empty code
      for (int i = 0; i < 32; i++) p1_write(4'((i * 3 + 1) & 15));
      tests++; if (code_len !== 6'd32) begin fails++; $display("FAIL full_len: got %0d expected 32", code_len); end
      p1_valid = 1'b1; p1_symbol = 4'hF;
      #1;
      tests++; if (p1_ready !== 1'b0 || ram_wren !== 1'b0) begin fails++; $display("FAIL full_ready: got %b%b expected 00", p1_ready, ram_wren); end
      @(negedge clock);
      p1_valid = 1'b0;
      tests++; if (code_len !== 6'd32) begin fails++; $display("FAIL full_nowrap: got %0d expected 32", code_len); end
      tests++; if (mem[0] !== 4'd1) begin fails++; $display("FAIL full_ram0: got %0d expected 1", mem[0]); end
      p1_finish();
      tests++; if (state !== 3'd2) begin fails++; $display("FAIL full_play: got %0d expected 2", state); end
      p2_quit();
      tests++; if (state !== 3'd4 || correct !== 1'b0) begin fails++; $display("FAIL quit_result: got %0d/%b expected 4/0", state, correct); end
   endtask

   task automatic test_same_cycle();
      pulse_start();
      p1_write(4'd5);
      p1_valid = 1'b1; p1_symbol = 4'd6; p1_done = 1'b1;
      #1;
      tests++; if (ram_wren !== 1'b1 || ram_addr !== 5'd1) begin fails++; $display("FAIL same_write: got %b@%0d expected 1@1", ram_wren, ram_addr); end
      @(negedge clock);
      p1_valid = 1'b0; p1_done = 1'b0;
      tests++; if (code_len !== 6'd2 || state !== 3'd2) begin fails++; $display("FAIL same_len: got %0d/%0d expected 2/2", code_len, state); end
      tests++; if (mem[1] !== 4'd6) begin fails++; $display("FAIL same_ram: got %0d expected 6", mem[1]); end
      pulse_start();
      tests++; if (state !== 3'd2 || code_len !== 6'd2) begin fails++; $display("FAIL start_ignored: got %0d/%0d expected 2/2", state, code_len); end
      p2_quit();
      pulse_start();
      p1_finish();
      tests++; if (state !== 3'd4 || correct !== 1'b0 || code_len !== 6'd0) begin
         fails++; $display("FAIL empty_code: got %0d/%b/%0d expected 4/0/0", state, correct, code_len);
      end
   endtask

   task automatic test_vga();
      vga_req = 1'b1; vga_addr = 5'd1;
      #1;
      tests++; if (vga_grant !== 1'b1 || ram_addr !== 5'd1 || ram_wren !== 1'b0) begin
         fails++; $display("FAIL vga_grant: got %b/%0d/%b expected 1/1/0", vga_grant, ram_addr, ram_wren);
      end
      @(negedge clock);
      tests++; if (ram_q !== 4'd6) begin fails++; $display("FAIL vga_read: got %0d expected 6", ram_q); end
      vga_req = 1'b0;
   endtask

   task automatic test_reset_mid_cmp();
      pulse_start();
      p1_write(4'd2); p1_write(4'd4);
      p1_finish();
      p2_valid = 1'b1; p2_symbol = 4'd2;
      @(negedge clock);
      p2_valid = 1'b0;
      tests++; if (state !== 3'd3) begin fails++; $display("FAIL pre_abort: got %0d expected 3", state); end
      #2 resetn = 1'b0;
      #1;
      tests++; if (state !== 3'd0 || code_len !== 6'd0 || match_cnt !== 6'd0) begin
         fails++; $display("FAIL abort_state: got %0d/%0d/%0d expected 0/0/0", state, code_len, match_cnt);
      end
      tests++; if ({result_valid, correct, p2_ready, ram_wren} !== 4'b0) begin
         fails++; $display("FAIL abort_flags: got %b expected 0000", {result_valid, correct, p2_ready, ram_wren});
      end
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      tests++; if (state !== 3'd0) begin fails++; $display("FAIL post_abort: got %0d expected 0", state); end
   endtask

   initial begin
      start = 0; p1_valid = 0; p1_symbol = 0; p1_done = 0;
      p2_valid = 0; p2_symbol = 0; p2_done = 0; vga_req = 0; vga_addr = 0;
      test_reset();
      test_record();
      test_replay_match();
      test_replay_mismatch();
      test_overflow();
      test_same_cycle();
      test_vga();
      test_reset_mid_cmp();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
